// File: rtl/rs_bank.sv
// Reservation station bank: holds dispatched ops until both operands are
// available, snoops the CDB for wakeup, and issues the oldest ready entry.
module rs_bank #(
    parameter int RS_DEPTH      = 4,
    parameter int TAG_BITS      = 5,
    parameter int XLEN          = 32,
    parameter int ALU_FUNC_BITS = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          disp_valid,
    input  logic [TAG_BITS-1:0]           disp_rob_tag,
    input  logic [XLEN-1:0]               disp_opa,
    input  logic [XLEN-1:0]               disp_opb,
    input  logic                          disp_opa_valid,
    input  logic                          disp_opb_valid,
    input  logic [TAG_BITS-1:0]           disp_opa_tag,
    input  logic [TAG_BITS-1:0]           disp_opb_tag,
    input  logic [ALU_FUNC_BITS-1:0]      disp_alu_func,
    input  logic [31:0]                   disp_npc,
    input  logic                          disp_rd_mem,
    input  logic                          disp_wr_mem,
    output logic                          disp_ready,
    output logic [$clog2(RS_DEPTH):0]     free_count,
    input  logic                          cdb_valid,
    input  logic [TAG_BITS-1:0]           cdb_tag,
    input  logic [XLEN-1:0]               cdb_data,
    output logic                          issue_valid,
    output logic [XLEN-1:0]               issue_opa,
    output logic [XLEN-1:0]               issue_opb,
    output logic [TAG_BITS-1:0]           issue_rob_tag,
    output logic [ALU_FUNC_BITS-1:0]      issue_alu_func,
    output logic [31:0]                   issue_npc,
    output logic                          issue_rd_mem,
    output logic                          issue_wr_mem,
    input  logic                          fu_ready,
    input  logic                          flush
);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                     valid;
        logic [XLEN-1:0]          opa;
        logic [XLEN-1:0]          opb;
        logic                     opa_valid;
        logic                     opb_valid;
        logic [TAG_BITS-1:0]      opa_tag;
        logic [TAG_BITS-1:0]      opb_tag;
        logic [TAG_BITS-1:0]      rob_tag;
        logic [ALU_FUNC_BITS-1:0] func;
        logic [31:0]              npc;
        logic                     rd_mem;
        logic                     wr_mem;
        logic [IW-1:0]            age;     // 0 = oldest; ranks are dense over valid entries
    } entry_t;

    entry_t ents [RS_DEPTH];

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] sel_age;
    logic [IW-1:0] disp_idx;
    logic [IW-1:0] new_age;
    logic          disp_fire;
    logic          issue_fire;
    logic          byp_a;
    logic          byp_b;
    entry_t        nent;

    // Oldest ready entry: smallest age rank among entries with both operands.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ents[i].valid && ents[i].opa_valid && ents[i].opb_valid &&
                (!sel_found || ents[i].age < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_age   = ents[i].age;
            end
        end
    end

    always_comb begin
        disp_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ents[i].valid) disp_idx = IW'(i);
        end
    end

    assign disp_ready  = (free_count != '0);
    assign issue_valid = sel_found;
    assign disp_fire   = disp_valid && disp_ready;
    assign issue_fire  = issue_valid && fu_ready;
    // New entry ranks behind every entry that survives this edge.
    assign new_age     = IW'(CW'(RS_DEPTH) - free_count - CW'(issue_fire));
    assign byp_a       = !disp_opa_valid && cdb_valid && (disp_opa_tag == cdb_tag);
    assign byp_b       = !disp_opb_valid && cdb_valid && (disp_opb_tag == cdb_tag);

    always_comb begin
        nent           = '0;
        nent.valid     = 1'b1;
        nent.opa       = byp_a ? cdb_data : disp_opa;
        nent.opb       = byp_b ? cdb_data : disp_opb;
        nent.opa_valid = disp_opa_valid || byp_a;
        nent.opb_valid = disp_opb_valid || byp_b;
        nent.opa_tag   = disp_opa_tag;
        nent.opb_tag   = disp_opb_tag;
        nent.rob_tag   = disp_rob_tag;
        nent.func      = disp_alu_func;
        nent.npc       = disp_npc;
        nent.rd_mem    = disp_rd_mem;
        nent.wr_mem    = disp_wr_mem;
        nent.age       = new_age;
    end

    always_comb begin
        issue_opa      = '0;
        issue_opb      = '0;
        issue_rob_tag  = '0;
        issue_alu_func = '0;
        issue_npc      = '0;
        issue_rd_mem   = 1'b0;
        issue_wr_mem   = 1'b0;
        if (issue_valid) begin
            issue_opa      = ents[sel_idx].opa;
            issue_opb      = ents[sel_idx].opb;
            issue_rob_tag  = ents[sel_idx].rob_tag;
            issue_alu_func = ents[sel_idx].func;
            issue_npc      = ents[sel_idx].npc;
            issue_rd_mem   = ents[sel_idx].rd_mem;
            issue_wr_mem   = ents[sel_idx].wr_mem;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) ents[i].valid <= 1'b0;
            free_count <= CW'(RS_DEPTH);
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ents[i].valid) begin
                    if (cdb_valid && !ents[i].opa_valid && ents[i].opa_tag == cdb_tag) begin
                        ents[i].opa       <= cdb_data;
                        ents[i].opa_valid <= 1'b1;
                    end
                    if (cdb_valid && !ents[i].opb_valid && ents[i].opb_tag == cdb_tag) begin
                        ents[i].opb       <= cdb_data;
                        ents[i].opb_valid <= 1'b1;
                    end
                    // Close the rank gap left by the issuing entry.
                    if (issue_fire && ents[i].age > sel_age) ents[i].age <= ents[i].age - 1'b1;
                end
            end
            if (issue_fire) ents[sel_idx].valid <= 1'b0;
            if (disp_fire)  ents[disp_idx] <= nent;
            free_count <= free_count - CW'(disp_fire) + CW'(issue_fire);
        end
    end
endmodule

// File: tb/tb_rs_bank.sv
// Directed vector bench for rs_bank: per-cycle stimulus with hand-computed
// expected issue/dispatch-status outputs, plus a held-selection sequence.
module tb_rs_bank;
    logic        clock = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic [4:0]  disp_rob_tag;
    logic [31:0] disp_opa, disp_opb;
    logic        disp_opa_valid, disp_opb_valid;
    logic [4:0]  disp_opa_tag, disp_opb_tag;
    logic [3:0]  disp_alu_func;
    logic [31:0] disp_npc;
    logic        disp_rd_mem, disp_wr_mem;
    logic        disp_ready;
    logic [2:0]  free_count;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        issue_valid;
    logic [31:0] issue_opa, issue_opb;
    logic [4:0]  issue_rob_tag;
    logic [3:0]  issue_alu_func;
    logic [31:0] issue_npc;
    logic        issue_rd_mem, issue_wr_mem;
    logic        fu_ready;
    logic        flush;

    int checks = 0;
    int errors = 0;

    rs_bank dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_rob_tag(disp_rob_tag),
        .disp_opa(disp_opa), .disp_opb(disp_opb),
        .disp_opa_valid(disp_opa_valid), .disp_opb_valid(disp_opb_valid),
        .disp_opa_tag(disp_opa_tag), .disp_opb_tag(disp_opb_tag),
        .disp_alu_func(disp_alu_func), .disp_npc(disp_npc),
        .disp_rd_mem(disp_rd_mem), .disp_wr_mem(disp_wr_mem),
        .disp_ready(disp_ready), .free_count(free_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_opa(issue_opa), .issue_opb(issue_opb),
        .issue_rob_tag(issue_rob_tag), .issue_alu_func(issue_alu_func),
        .issue_npc(issue_npc), .issue_rd_mem(issue_rd_mem), .issue_wr_mem(issue_wr_mem),
        .fu_ready(fu_ready), .flush(flush)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        dv;
        logic [4:0]  rob;
        logic [31:0] opa;
        logic        av;
        logic [4:0]  atag;
        logic [31:0] opb;
        logic        bv;
        logic [4:0]  btag;
        logic        cv;
        logic [4:0]  ctag;
        logic [31:0] cdata;
        logic        fu, fl, rs;
        logic        e_iv;
        logic [4:0]  e_tag;
        logic [31:0] e_opa, e_opb;
        logic        e_dr;
        logic [2:0]  e_fc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int dv, rob, opa, av, atag, opb, bv, btag,
                                input int cv, ctag, cdata, fu, fl, rs,
                                input int iv, tg, ea, eb, dr, fc);
        vec_t m;
        m.dv = dv[0]; m.rob = rob[4:0]; m.opa = opa; m.av = av[0]; m.atag = atag[4:0];
        m.opb = opb; m.bv = bv[0]; m.btag = btag[4:0];
        m.cv = cv[0]; m.ctag = ctag[4:0]; m.cdata = cdata;
        m.fu = fu[0]; m.fl = fl[0]; m.rs = rs[0];
        m.e_iv = iv[0]; m.e_tag = tg[4:0]; m.e_opa = ea; m.e_opb = eb;
        m.e_dr = dr[0]; m.e_fc = fc[2:0];
        return m;
    endfunction

    function automatic vec_t idle(input int fu, iv, tg, ea, eb, dr, fc);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fu, 0, 0, iv, tg, ea, eb, dr, fc);
    endfunction

    task automatic drive(input vec_t v);
        disp_valid     = v.dv;
        disp_rob_tag   = v.rob;
        disp_opa       = v.opa;
        disp_opa_valid = v.av;
        disp_opa_tag   = v.atag;
        disp_opb       = v.opb;
        disp_opb_valid = v.bv;
        disp_opb_tag   = v.btag;
        disp_alu_func  = 4'h3;
        disp_npc       = {25'd0, v.rob, 2'b00};
        disp_rd_mem    = v.rob[0];
        disp_wr_mem    = 1'b0;
        cdb_valid      = v.cv;
        cdb_tag        = v.ctag;
        cdb_data       = v.cdata;
        fu_ready       = v.fu;
        flush          = v.fl;
        reset          = v.rs;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        int n;
        v = idle(0, 0, 0, 0, 0, 1, 4);
        drive(v);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // basic ADD
        tbl.push_back(mk(1, 1, 5, 1, 0, 3, 1, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(idle(1, 1, 1, 5, 3, 1, 3));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));
        // dependency resolved by CDB two cycles later
        tbl.push_back(mk(1, 2, 0, 0, 1, 5, 1, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 30, 1, 0, 0,  0, 0, 0, 0, 1, 3));
        tbl.push_back(idle(1, 1, 2, 30, 5, 1, 3));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));
        // fill with fu stalled, 5th dispatch refused
        tbl.push_back(mk(1, 10, 100, 1, 0, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 11, 101, 1, 0, 2, 1, 0,  0, 0, 0,  0, 0, 0,  1, 10, 100, 1, 1, 3));
        tbl.push_back(mk(1, 12, 102, 1, 0, 3, 1, 0,  0, 0, 0,  0, 0, 0,  1, 10, 100, 1, 1, 2));
        tbl.push_back(mk(1, 13, 103, 1, 0, 4, 1, 0,  0, 0, 0,  0, 0, 0,  1, 10, 100, 1, 1, 1));
        tbl.push_back(mk(1, 14, 104, 1, 0, 5, 1, 0,  0, 0, 0,  0, 0, 0,  1, 10, 100, 1, 0, 0));
        tbl.push_back(idle(1, 1, 10, 100, 1, 0, 0));
        // simultaneous dispatch + issue keeps free_count; new entry is youngest
        tbl.push_back(mk(1, 20, 200, 1, 0, 6, 1, 0,  0, 0, 0,  1, 0, 0,  1, 11, 101, 2, 1, 1));
        tbl.push_back(idle(1, 1, 12, 102, 3, 1, 1));
        tbl.push_back(idle(1, 1, 13, 103, 4, 1, 2));
        tbl.push_back(idle(1, 1, 20, 200, 6, 1, 3));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));
        // out-of-order ready
        tbl.push_back(mk(1, 4, 0, 0, 9, 7, 1, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 5, 50, 1, 0, 51, 1, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 3));
        tbl.push_back(idle(1, 1, 5, 50, 51, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 9, 90, 1, 0, 0,  0, 0, 0, 0, 1, 3));
        tbl.push_back(idle(1, 1, 4, 90, 7, 1, 3));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));
        // dispatch-cycle bypass
        tbl.push_back(mk(1, 6, 1, 1, 0, 0, 0, 7,  1, 7, 'hAA, 1, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(idle(1, 1, 6, 1, 'hAA, 1, 3));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));
        // flush with 3 pending, beating dispatch and CDB in the same cycle
        tbl.push_back(mk(1, 21, 0, 0, 3, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 22, 220, 1, 0, 2, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(1, 23, 230, 1, 0, 3, 1, 0,  0, 0, 0,  0, 0, 0,  1, 22, 220, 2, 1, 2));
        tbl.push_back(mk(1, 24, 240, 1, 0, 4, 1, 0,  1, 3, 33, 0, 1, 0,  1, 22, 220, 2, 1, 1));
        tbl.push_back(idle(0, 0, 0, 0, 0, 1, 4));
        // same with reset
        tbl.push_back(mk(1, 21, 0, 0, 3, 1, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 4));
        tbl.push_back(mk(1, 22, 220, 1, 0, 2, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 3));
        tbl.push_back(mk(1, 23, 230, 1, 0, 3, 1, 0,  0, 0, 0,  0, 0, 0,  1, 22, 220, 2, 1, 2));
        tbl.push_back(mk(1, 24, 240, 1, 0, 4, 1, 0,  1, 3, 33, 0, 0, 1,  1, 22, 220, 2, 1, 1));
        tbl.push_back(idle(0, 0, 0, 0, 0, 1, 4));
        tbl.push_back(idle(1, 0, 0, 0, 0, 1, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d issue_valid", i), 32'(issue_valid), 32'(tbl[i].e_iv));
            chk($sformatf("v%0d issue_rob_tag", i), 32'(issue_rob_tag), 32'(tbl[i].e_tag));
            chk($sformatf("v%0d issue_opa", i), issue_opa, tbl[i].e_opa);
            chk($sformatf("v%0d issue_opb", i), issue_opb, tbl[i].e_opb);
            chk($sformatf("v%0d issue_npc", i), issue_npc, tbl[i].e_iv ? {25'd0, tbl[i].e_tag, 2'b00} : 32'd0);
            chk($sformatf("v%0d disp_ready", i), 32'(disp_ready), 32'(tbl[i].e_dr));
            chk($sformatf("v%0d free_count", i), 32'(free_count), 32'(tbl[i].e_fc));
        end

        // selection holds while fu stalled; a waiting entry wakes meanwhile
        @(negedge clock);
        drive(mk(1, 8, 80, 1, 0, 81, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 4));
        @(negedge clock);
        drive(mk(1, 9, 90, 1, 0, 0, 0, 8,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 4));
        #1 chk("hold first tag", 32'(issue_rob_tag), 32'd8);
        @(negedge clock);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 8, 'h123, 0, 0, 0,  0, 0, 0, 0, 1, 4));
        #1 chk("hold under cdb", 32'(issue_rob_tag), 32'd8);
        @(negedge clock);
        drive(idle(0, 0, 0, 0, 0, 1, 4));
        #1 chk("hold alu_func", 32'(issue_alu_func), 32'd3);
        chk("hold free_count", 32'(free_count), 32'd2);
        @(negedge clock);
        drive(idle(1, 0, 0, 0, 0, 1, 4));
        #1 chk("release tag", 32'(issue_rob_tag), 32'd8);
        chk("release opb", issue_opb, 32'd81);
        n = 0;
        @(negedge clock);
        while (!(issue_valid && issue_rob_tag == 5'd9) && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("wake wait bound", 32'(n < 10), 32'd1);
        chk("wake opa", issue_opa, 32'd90);
        chk("wake opb", issue_opb, 32'h123);
        chk("wake rd_mem", 32'(issue_rd_mem), 32'd1);
        @(negedge clock);
        #1 chk("drained valid", 32'(issue_valid), 32'd0);
        chk("drained free_count", 32'(free_count), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rs_bank.md
RS_BANK -- requirements
Module: rs_bank

Interface
REQ-001 Parameter RS_DEPTH, default 4: number of entries, power of two, 2..16.
REQ-002 Parameter TAG_BITS, default 5: width of ROB and CDB tags.
REQ-003 Parameter XLEN, default 32: operand and result width.
REQ-004 Ports `clock` and `reset` form the only clock domain; reset is synchronous and active-high.
REQ-005 Dispatch ports, all inputs:
- `disp_valid` 1
- `disp_rob_tag` TAG_BITS
- `disp_opa`, `disp_opb` XLEN each
- `disp_opa_valid`, `disp_opb_valid` 1 each; operand holds a value, else a producer tag
- `disp_opa_tag`, `disp_opb_tag` TAG_BITS each
- `disp_alu_func` ALU_FUNC
- `disp_npc` 32
- `disp_rd_mem`, `disp_wr_mem` 1 each
REQ-006 Dispatch status outputs: `disp_ready` 1 (an entry is free); `free_count` $clog2(RS_DEPTH)+1.
REQ-007 CDB inputs: `cdb_valid` 1, `cdb_tag` TAG_BITS, `cdb_data` XLEN.
REQ-008 Issue ports:
- Outputs: `issue_valid` 1, `issue_opa`/`issue_opb` XLEN, `issue_rob_tag` TAG_BITS, `issue_alu_func` ALU_FUNC, `issue_npc` 32, `issue_rd_mem`/`issue_wr_mem` 1.
- Input: `fu_ready` 1.
REQ-009 Input `flush` 1: squash all entries.

Function
REQ-010 Entry state: valid, both operands, both operand-valid bits, both tags, rob_tag, func, npc, rd_mem, wr_mem, and an age rank.
REQ-011 Dispatch handshake:
- An entry is written at the clock edge when disp_valid && disp_ready.
- The written entry is the lowest-index invalid entry.
- When the handshake does not complete, dispatch is ignored and no state changes.
REQ-012 disp_ready is derived from registered state only, so a full bank refuses dispatch even in a cycle where an entry issues.
REQ-013 CDB wakeup: when cdb_valid is high, every valid entry whose operand is not valid and whose tag equals cdb_tag captures cdb_data and sets the operand-valid bit at the clock edge.
REQ-014 Dispatch-cycle bypass: a dispatched operand with valid=0 whose tag equals cdb_tag while cdb_valid is high is stored as valid with cdb_data.
REQ-015 Ready condition: an entry is ready when it is valid and both operand-valid bits are set, evaluated on registered state. The earliest issue is therefore the cycle after dispatch or after capture.
REQ-016 issue_valid is combinational: high when any entry is ready. Issue outputs present the oldest ready entry, meaning the earliest-dispatched one. Outputs are 0 when issue_valid is low.
REQ-017 Issue handshake:
- Completes when issue_valid && fu_ready.
- The selected entry is invalidated at the clock edge.
- When fu_ready is low, the selection holds and no entry changes except through CDB capture.
REQ-018 Age order is preserved across arbitrary frees. The oldest-first rule holds after any interleaving of dispatch and issue.
REQ-019 Simultaneous dispatch and issue in one cycle are both performed, and free_count is unchanged.
REQ-020 free_count always equals RS_DEPTH minus the number of valid entries. It is registered and updated at every edge.
REQ-021 flush:
- At the clock edge, invalidates every entry and sets free_count to RS_DEPTH.
- Takes priority over dispatch, issue, and capture in the same cycle.
- Issue outputs stay combinational, so an issue handshake in the flush cycle still presents the entry to the FU.
REQ-022 Tag values carry no reserved encoding; only the operand-valid bits decide readiness.

Reset
REQ-023 While reset is high at a clock edge, all entries are invalidated and free_count is set to RS_DEPTH.
REQ-024 After reset: disp_ready=1, issue_valid=0, and all issue data outputs read 0.
REQ-025 Reset asserted mid-operation discards pending entries and has priority over flush, dispatch, and CDB.

Verification
REQ-026 Basic ADD: dispatch ADD opa=5, opb=3, both valid, rob_tag=1, fu_ready=1 -> next cycle issue_valid=1, opa=5, opb=3, rob_tag=1; then free_count returns to 4.
REQ-027 Dependency:
- Dispatch tag 2 with opa_valid=0, opa_tag=1, opb=5.
- Drive CDB tag=1, data=30 two cycles later.
- Required: no issue before the capture; issue_valid the cycle after capture with opa=30, opb=5.
REQ-028 Fill and order:
- Dispatch 4 ready entries, tags 10..13, fu_ready=0 -> disp_ready=0 and free_count=0; a 5th dispatch is ignored.
- Raise fu_ready -> issue order 10, 11, 12, 13, one per cycle.
REQ-029 Out-of-order ready:
- Dispatch tag 4 waiting on tag 9, then tag 5 ready.
- Required: tag 5 issues first.
- Then CDB tag 9 -> tag 4 issues.
REQ-030 Bypass: dispatch opb_valid=0, opb_tag=7 in the same cycle as CDB tag=7, data=0xAA -> entry issues next cycle with opb=0xAA.
REQ-031 Flush and reset: with 3 entries pending, assert flush for one cycle -> free_count=4 and issue_valid=0. Repeat with reset -> same result.
